inst_rom_loader: RTL and testbench
==================================

Name: inst_rom_loader

Overview:
- Boot-time sequencer for the instruction ROM.
- Accepts a byte stream over a valid/ready handshake, e.g. from a UART receiver or a bench driver.
- Assembles little-endian 32-bit words and drives the ROM write port (write_enable, byte address, instruction word).
- Holds the CPU in reset during loading, then releases it and asserts the CPU read enable.

Parameters:
- MEM_WORDS, 256, ROM depth in words; upper bound for the header word count.
- CNT_W, 9, width of the word counter; must satisfy 2^CNT_W > MEM_WORDS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a new load session
- byte_valid  in  1  stream byte present
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- rom_write_enable  out  1  ROM write strobe, one cycle per word
- rom_addr  out  32  ROM byte address, word aligned (word_idx << 2)
- rom_inst  out  32  instruction word to write
- cpu_read_enable  out  1  enables CPU fetch from ROM
- cpu_reset  out  1  holds CPU in reset while high
- busy  out  1  high in HDR, LOAD, WRITE
- done  out  1  high in RUN
- error  out  1  high in ERR

Behaviour:
- Reset state after rst: IDLE. Output values:
  - cpu_reset=1
  - cpu_read_enable=0
  - byte_ready=0
  - rom_write_enable=0
  - rom_addr=0, rom_inst=0
  - busy=0, done=0, error=0
  - byte counter=0, word_idx=0, word count N=0
- A byte transfer occurs on a clk edge where byte_valid && byte_ready.
- Bytes are shifted in little-endian: byte k of a group lands in bits [8k+7:8k].
- States and transitions:
  - IDLE: byte_ready=0. start -> HDR.
  - HDR: byte_ready=1. After 4 transfers the header word is N (32 bits).
    - N==0 -> RUN.
    - N>MEM_WORDS -> ERR.
    - Otherwise -> LOAD, with word_idx=0.
  - LOAD: byte_ready=1. On the 4th transfer of a word, the assembled word is registered into rom_inst, rom_addr is set to word_idx*4, and the state moves to WRITE.
  - WRITE: exactly one cycle. rom_write_enable=1, byte_ready=0, so a byte offered in this cycle is held by the sender. word_idx increments at the end of the cycle.
    - If word_idx+1==N -> RUN.
    - Otherwise -> LOAD.
  - RUN: cpu_reset=0, cpu_read_enable=1, done=1, byte_ready=0. start -> HDR, with cpu_reset=1 and cpu_read_enable=0 from the next cycle.
  - ERR: error=1, cpu_reset=1, byte_ready=0. Only start (-> HDR) or rst leaves ERR.
- Latency: from the 4th byte of the final word to the first cycle with cpu_reset=0 is 2 clk (one LOAD->WRITE edge, one WRITE->RUN edge).
- start is ignored in HDR, LOAD and WRITE; an in-progress load is not aborted.
- rst in any state, including mid-word or during WRITE, forces IDLE with reset values. A partially assembled word is discarded and no write is issued.
- Addresses issued are 0, 4, ..., 4*(N-1); word_idx never wraps because N<=MEM_WORDS.
- Entering HDR clears the byte counter, word_idx, N and error.
- rom_write_enable is never asserted outside WRITE.

Decomposition:
- Shared package holds:
  - state encoding IDLE=0, HDR=1, LOAD=2, WRITE=3, RUN=4, ERR=5;
  - localparam NOP_INST=32'h00000013 (used by the ROM for out-of-range fetch; the loader does not write it).
- One sub-module is natural: byte_packer. It is a 4-byte little-endian shift assembler with a 2-bit counter and a word_valid pulse, and is reused for both the header and the data words.

Test Plan:
- rst, start, header bytes 02 00 00 00, then 13 00 00 00 and 93 00 10 00, byte_valid held high -> writes (addr 0, 32'h00000013) and (addr 4, 32'h00100093); each write is one cycle with byte_ready=0; cpu_reset falls 2 cycles after the last byte; done=1.
- Header 00 00 00 00 -> RUN directly, no rom_write_enable pulses.
- Header 01 01 00 00 (N=257) -> ERR, error=1, cpu_reset stays 1; a following start clears error and enters HDR.
- Header N=256 streamed in full -> last write at addr 0x3FC, then RUN, no further writes.
- byte_valid toggled randomly -> words still assemble correctly; no byte lost or duplicated across WRITE bubbles.
- rst asserted after the 2nd byte of word 1 -> next cycle in IDLE, outputs at reset values, no write issued; a reload from start behaves as in the first scenario.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM boot loader.
// Holds the sequencer state encoding and the word/byte address helper.
package inst_rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Returned by the ROM for fetches beyond the loaded image; never written here.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] word_idx);
        return word_idx << 2;
    endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte stream valid/ready handshake feeding the loader.
// The master is the byte source, the slave is the loader.
interface inst_rom_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/inst_rom_loader_byte_packer.sv
// Little-endian 4-byte assembler; shared by header and data words.
// word/word_valid are combinational on the 4th byte so the caller can register the word on that edge.
module inst_rom_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en) begin
            shift_q <= {byte_data, shift_q[23:8]};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    // Earlier bytes have drifted down to the low lanes; the live byte is the top one.
    assign word       = {byte_data, shift_q};
    assign word_valid = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_rom_loader.sv
// Boot-time sequencer: reads a word-count header and an image from a byte stream,
// writes it to the instruction ROM, then releases the CPU from reset.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int CNT_W     = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    inst_rom_loader_if.slave   stream,
    output logic               rom_write_enable,
    output logic [31:0]        rom_addr,
    output logic [31:0]        rom_inst,
    output logic               cpu_read_enable,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               error
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   word_idx_q, word_idx_d;
    logic [31:0]        n_q, n_d;
    logic [31:0]        rom_addr_q, rom_addr_d;
    logic [31:0]        rom_inst_q, rom_inst_d;

    logic               byte_ready;
    logic               byte_en;
    logic               packer_clear;
    logic [31:0]        word;
    logic               word_valid;
    logic [CNT_W-1:0]   word_idx_inc;
    logic               last_word;

    assign byte_ready        = (state_q == ST_HDR) || (state_q == ST_LOAD);
    assign byte_en           = stream.byte_valid && byte_ready;
    assign stream.byte_ready = byte_ready;

    inst_rom_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_en    (byte_en),
        .byte_data  (stream.byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign word_idx_inc = word_idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_word    = (32'(word_idx_inc) == n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            n_q        <= '0;
            rom_addr_q <= '0;
            rom_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            n_q        <= n_d;
            rom_addr_q <= rom_addr_d;
            rom_inst_q <= rom_inst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        n_d          = n_q;
        rom_addr_d   = rom_addr_q;
        rom_inst_d   = rom_inst_q;
        packer_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d      = ST_HDR;
                    word_idx_d   = '0;
                    n_d          = '0;
                    packer_clear = 1'b1;
                end
            end
            ST_HDR: begin
                if (word_valid) begin
                    n_d        = word;
                    word_idx_d = '0;
                    if (word == 32'd0)
                        state_d = ST_RUN;
                    else if (word > 32'(MEM_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    rom_inst_d = word;
                    rom_addr_d = word_byte_addr(32'(word_idx_q));
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = last_word ? ST_RUN : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_write_enable = (state_q == ST_WRITE);
    assign rom_addr         = rom_addr_q;
    assign rom_inst         = rom_inst_q;
    assign cpu_read_enable  = (state_q == ST_RUN);
    assign cpu_reset        = (state_q != ST_RUN);
    assign busy             = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done             = (state_q == ST_RUN);
    assign error            = (state_q == ST_ERR);

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomised self-checking bench for inst_rom_loader: a write scoreboard built from the
// byte image, per-cycle control invariants, and literal pins for the directed scenarios.
module tb_inst_rom_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rom_write_enable;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        cpu_read_enable;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int gap_pct  = 0;
    int inj_pct  = 0;
    bit mon_en   = 1'b0;

    wr_t         exp_q[$];
    wr_t         log_q[$];
    logic [31:0] img[256];

    inst_rom_loader_if bus ();

    inst_rom_loader #(.MEM_WORDS(256), .CNT_W(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stream           (bus.slave),
        .rom_write_enable (rom_write_enable),
        .rom_addr         (rom_addr),
        .rom_inst         (rom_inst),
        .cpu_read_enable  (cpu_read_enable),
        .cpu_reset        (cpu_reset),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard and control invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            wr_t e;
            int  nstat;
            check("write_bubble_ready", {31'b0, rom_write_enable && bus.byte_ready}, 32'd0);
            check("run_controls", {30'b0, cpu_read_enable, done}, {30'b0, !cpu_reset, !cpu_reset});
            nstat = int'(busy) + int'(done) + int'(error);
            check("status_exclusive", {31'b0, nstat > 1}, 32'd0);
            if (rom_write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr %h inst %h required=no write", rom_addr, rom_inst);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", rom_addr, e.addr);
                    check("write_inst", rom_inst, e.inst);
                end
                log_q.push_back('{addr: rom_addr, inst: rom_inst});
                wr_count++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input bit with_start);
        int t;
        @(negedge clk);
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        start          = with_start;
        t = 0;
        while (!bus.byte_ready) begin
            @(negedge clk);
            start = 1'b0;
            t++;
            if (t > 50) begin
                $display("FAIL byte_accept_timeout actual=ready low %0d cycles required=ready", t);
                $fatal(1, "byte never accepted");
            end
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        start          = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (inj_pct > 0) && ($urandom_range(99) < inj_pct));
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hdr_busy", {31'b0, busy}, 32'd1);
        check("hdr_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("hdr_error_clear", {31'b0, error}, 32'd0);
    endtask

    // One load session; expectations come from the header value and the image alone.
    task automatic run_load(input logic [31:0] n);
        int wr0;
        wr0 = wr_count;
        start_pulse();
        send_word(n);
        if (n == 32'd0) begin
            @(negedge clk);
            check("empty_done", {31'b0, done}, 32'd1);
            check("empty_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        end else if (n > 32'd256) begin
            @(negedge clk);
            check("err_flag", {31'b0, error}, 32'd1);
            check("err_cpu_reset", {31'b0, cpu_reset}, 32'd1);
            check("err_busy", {31'b0, busy}, 32'd0);
            repeat (3) @(negedge clk);
            check("err_sticky", {31'b0, error}, 32'd1);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back('{addr: 32'(i * 4), inst: img[i]});
                send_word(img[i]);
            end
            @(negedge clk);
            check("lat1_write", {31'b0, rom_write_enable}, 32'd1);
            check("lat1_cpu_reset", {31'b0, cpu_reset}, 32'd1);
            @(negedge clk);
            check("lat2_cpu_reset", {31'b0, cpu_reset}, 32'd0);
            check("lat2_done", {31'b0, done}, 32'd1);
        end
        repeat (3) @(negedge clk);
        check("write_count", 32'(wr_count - wr0), (n > 32'd256) ? 32'd0 : n);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int wr0;
        rst = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst_read_en", {31'b0, cpu_read_enable}, 32'd0);
        check("rst_ready", {31'b0, bus.byte_ready}, 32'd0);
        check("rst_addr", rom_addr, 32'd0);
        check("rst_inst", rom_inst, 32'd0);
        check("rst_status", {29'b0, busy, done, error}, 32'd0);

        // Two-word image with byte_valid held high.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        log_q.delete();
        run_load(32'd2);
        check("pin_w0_addr", log_q[0].addr, 32'h0000_0000);
        check("pin_w0_inst", log_q[0].inst, 32'h0000_0013);
        check("pin_w1_addr", log_q[1].addr, 32'h0000_0004);
        check("pin_w1_inst", log_q[1].inst, 32'h0010_0093);

        run_load(32'd0);
        run_load(32'h0000_0101);
        check("pin_err_done", {31'b0, done}, 32'd0);

        // Full-depth image with a sparse stream.
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        gap_pct = 20;
        log_q.delete();
        run_load(32'd256);
        check("pin_last_addr", log_q[log_q.size()-1].addr, 32'h0000_03FC);
        check("pin_last_inst", log_q[log_q.size()-1].inst, img[255]);

        // Random sessions: gappy stream and start pulses that must be ignored mid-load.
        gap_pct = 40;
        inj_pct = 10;
        for (int s = 0; s < 6; s++) begin
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load(32'(n));
        end
        inj_pct = 0;
        gap_pct = 0;

        // Reset mid-word: the partial word must vanish without a write.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        start_pulse();
        send_word(32'd2);
        exp_q.push_back('{addr: 32'd0, inst: img[0]});
        send_word(img[0]);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        wr0 = wr_count;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("mid_rst_ready", {31'b0, bus.byte_ready}, 32'd0);
        check("mid_rst_inst", rom_inst, 32'd0);
        check("mid_rst_addr", rom_addr, 32'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_no_write", 32'(wr_count - wr0), 32'd0);
        check("mid_rst_scoreboard", 32'(exp_q.size()), 32'd0);
        log_q.delete();
        run_load(32'd2);
        check("reload_w1_inst", log_q[1].inst, 32'h0010_0093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
